// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the four-digit seven-segment scan driver.
//   NUM_DIGITS : number of multiplexed digits
//   HEX_SEG    : hex nibble -> segment pattern, bit order {g,f,e,d,c,b,a}, active-high
//   state_e    : scan FSM states (BLANK guard interval, DRIVE digit on)
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [0:0] {
    BLANK,
    DRIVE
  } state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// seg7_tick_gen: digit-slot prescaler. Counts 0..TICK_DIV-1 and wraps.
// Ports:
//   clk  : system clock
//   res  : asynchronous active-low reset
//   tick : high during the last cycle of each slot (count == TICK_DIV-1)
module seg7_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic res,
  output logic tick
);

  logic [15:0] tick_cnt;

  assign tick = (tick_cnt == 16'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: tear-free, ghost-suppressed driver for four common-anode hex digits.
// A CPU write lands in a shadow register; the shadow is copied to the display register
// only when the slot index wraps to 0, so a frame never mixes two values.
// Each slot starts with a blanking guard (all digits off) before the digit is driven.
// Ports:
//   clk         : system clock
//   res         : asynchronous active-low reset
//   wr_en       : one-cycle write strobe (display register store)
//   wr_data     : 16-bit value, nibble [15:12] shown leftmost
//   dp_in       : decimal-point enables, bit k for digit k, sampled with wr_en
//   dig         : active-low digit enables, dig[3] leftmost
//   seg         : active-low segments, seg[6:0] = ~{g,f,e,d,c,b,a}, seg[7] = ~dp
//   frame_start : one-cycle pulse when the slot index wraps to 0 and the display reloads
// Build option: define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned GUARD_CYC = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  wr_en,
  input  logic [15:0]           wr_data,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic [NUM_DIGITS-1:0] dig,
  output logic [7:0]            seg,
  output logic                  frame_start
);

  logic                  tick;
  logic [15:0]           shadow, disp;
  logic [NUM_DIGITS-1:0] shadow_dp, disp_dp;
  logic [1:0]            idx;
  state_e                state;
  logic [15:0]           guard_cnt;
  logic                  guard_done;
  logic [3:0]            nib;
  logic                  dp_bit;
  logic                  lz_blank;
  logic [3:0]            dig_drive;
  logic [7:0]            seg_drive;

  seg7_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .res (res),
    .tick(tick)
  );

  // GUARD_CYC == 0 still yields a single blank cycle.
  assign guard_done = ({16'd0, guard_cnt} + 32'd1) >= GUARD_CYC;

  always_comb begin
    nib      = disp[15:12];
    lz_blank = 1'b0;
    unique case (idx)
      2'd0: nib = disp[15:12];
      2'd1: nib = disp[11:8];
      2'd2: nib = disp[7:4];
      2'd3: nib = disp[3:0];
    endcase
`ifdef SEG7_LZB_EN
    // Rightmost digit (idx 3) is never blanked.
    unique case (idx)
      2'd0: lz_blank = (disp[15:12] == 4'd0);
      2'd1: lz_blank = (disp[15:8] == 8'd0);
      2'd2: lz_blank = (disp[15:4] == 12'd0);
      2'd3: lz_blank = 1'b0;
    endcase
`endif
    dp_bit    = disp_dp[2'd3 - idx];
    dig_drive = ~(4'b1000 >> idx);
    seg_drive = ~{dp_bit, (lz_blank ? 7'h00 : hex_to_seg(nib))};
  end

  // Shadow capture: last write wins.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      shadow    <= '0;
      shadow_dp <= '0;
    end else if (wr_en) begin
      shadow    <= wr_data;
      shadow_dp <= dp_in;
    end
  end

  // Slot index and frame-boundary reload.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      idx         <= 2'd0;
      disp        <= '0;
      disp_dp     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && (idx == 2'd3);
      if (tick) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          disp    <= shadow;
          disp_dp <= shadow_dp;
        end
      end
    end
  end

  // Scan FSM with registered outputs; idx/disp update on the same tick edge that
  // enters BLANK, so the decode seen in BLANK already belongs to the new slot.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= BLANK;
      guard_cnt <= '0;
      dig       <= 4'b1111;
      seg       <= 8'hFF;
    end else if (tick) begin
      state     <= BLANK;
      guard_cnt <= '0;
      dig       <= 4'b1111;
      seg       <= 8'hFF;
    end else begin
      unique case (state)
        BLANK: begin
          if (guard_done) begin
            state <= DRIVE;
            dig   <= dig_drive;
            seg   <= seg_drive;
          end else begin
            guard_cnt <= guard_cnt + 16'd1;
          end
        end
        DRIVE: begin
          dig <= dig_drive;
          seg <= seg_drive;
        end
      endcase
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream consumer of the CPU's memory-mapped display register (RAM address 1 write) on the tester board. Captures 16-bit write data into a shadow register and transfers it to the display register only at frame boundaries, so the display never tears. Time-multiplexes four common-anode hex digits with a blanking guard between digits to suppress ghosting. Drives the board's active-low dig/seg pins directly.

Parameters:
TICK_DIV, 50000, clk cycles per digit slot (1 kHz at 50 MHz); legal range 4..65535.
GUARD_CYC, 16, cycles per slot with all digits off before the new digit is driven; must be < TICK_DIV-1.

Ports:
clk  in  1  system clock, single clock domain
res  in  1  asynchronous active-low reset
wr_en  in  1  one-cycle strobe: CPU store to display address
wr_data  in  16  value to display; nibble [15:12] shown leftmost
dp_in  in  4  decimal-point enables, bit k belongs to digit k; sampled with wr_en
dig  out  4  digit enables, active-low; dig[3] is the leftmost digit (nibble [15:12])
seg  out  8  segments, active-low; seg[6:0] = ~{g,f,e,d,c,b,a}, seg[7] = ~dp
frame_start  out  1  one-cycle pulse when slot index wraps to 0 and display register reloads

Behaviour:
- Reset (res=0, async): dig=4'b1111, seg=8'hFF, frame_start=0, shadow=0, disp=0, dp regs=0, tick counter=0, slot index=0, FSM=BLANK.
- While res=0 all outputs hold reset values; the first slot begins on the first clk edge after release.
- Shadow: wr_en=1 at edge t loads wr_data/dp_in; the value is visible in shadow after edge t. Back-to-back writes: last one wins.
- Prescaler: tick_cnt counts 0..TICK_DIV-1 and wraps; tick asserts when tick_cnt==TICK_DIV-1.
- Slot index idx (2 bits): increments on tick, wraps 3->0. Digit driven in slot idx is dig[3-idx] (idx 0 = leftmost).
- Frame reload: on the tick that sets idx to 0, disp <= shadow (pre-edge value) and frame_start pulses for one cycle. A wr_en coinciding with that tick lands in shadow and appears next frame. Latency from write to visible digit is at most 4*TICK_DIV+GUARD_CYC+1 cycles.
- FSM, registered outputs:
  BLANK: dig=1111, seg=FF. Counts GUARD_CYC cycles, then goes to DRIVE.
  DRIVE: dig = one-hot-low for the current slot; seg = ~{dp, hexcode(nibble)}. On tick, goes to BLANK.
- Hex codes (gfedcba), 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Never more than one dig bit low; dig and seg change on the same edge.
- GUARD_CYC=0: BLANK lasts exactly 1 cycle.

Optional Feature:
SEG7_LZB_EN: when defined, leading-zero blanking is enabled. In DRIVE, a digit whose nibble and all more-significant nibbles are 0 shows seg=FF (its dp still honoured) while dig stays active. The rightmost digit is never blanked, so 0x0000 shows a single "0". When undefined, all four digits always show their hex glyph.

Decomposition:
- Package seg7_pkg: NUM_DIGITS=4; 16-entry hex-to-segment constant table (gfedcba, active-high); FSM state enum {BLANK, DRIVE}.
- Sub-module seg7_tick_gen: prescaler with TICK_DIV parameter, clk/res, tick output. Decode and FSM stay in the top.

Test Plan:
- Reset: hold res=0 for 10 cycles mid-DRIVE -> dig=1111, seg=FF, frame_start=0 immediately and throughout.
- TICK_DIV=8, GUARD_CYC=2, write 16'h1234 -> after the next frame_start, slots show dig=0111/seg=F9, 1011/A4, 1101/B0, 1110/99, each preceded by 2 cycles of dig=1111.
- Write 16'hABCD exactly on the frame-boundary tick -> the current frame still shows the old value; the next frame shows 88,83,C6,A1.
- Two writes 16'h0001 then 16'hFFFF on consecutive cycles within one frame -> the next frame shows FFFF (8E on all digits).
- dp_in=4'b0001 with 16'h0000 -> rightmost digit seg=40 (dp on); with SEG7_LZB_EN the other three digits show seg=FF and the rightmost shows 40.
- Assertion over a 10k-cycle random-write run: $countones(~dig)<=1 at all times; frame_start period = 4*TICK_DIV.
